// File: rtl/sample_readout_pkg.sv
// Shared types and constants for the sample read-out path.
//   state_t          : read-out FSM states
//   HEADER_DEFAULT   : default frame start byte
//   BYTES_PER_SAMPLE : bytes emitted per FIFO sample (high byte first)
package sample_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_SEND_LO = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
  localparam int         BYTES_PER_SAMPLE = 2;

endpackage

// File: rtl/sample_readout_sync_2ff.sv
// Two-flop synchroniser for a single level signal crossing into clk.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input level
//   q   : synchronised level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sample_readout.sv
// Drains one frame of samples from the async sample FIFO once the write side
// reports full, and streams it to the host-link transmitter as
// HEADER, {hi, lo} per sample over a valid/ready byte interface.
//   clk_i, rst_i   : read-domain clock, synchronous active-high reset
//   fifo_data_i    : FIFO read data, valid the cycle after r_en_o
//   fifo_empty_i   : FIFO empty (read domain)
//   fifo_full_i    : FIFO full (write domain, synchronised here)
//   r_en_o         : one-cycle FIFO read strobe per sample
//   tx_data_o/tx_valid_o/tx_ready_i : byte stream to the transmitter
//   busy_o         : frame in progress
//   frame_done_o   : one-cycle pulse at frame end
module sample_readout
  import sample_readout_pkg::*;
#(
  parameter int         DATA_SIZE = 12,
  parameter int         ADDR_SIZE = 8,
  parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_SIZE-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_full_i,
  output logic                 r_en_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  // Width of the high byte's payload; the rest of that byte is zero.
  localparam int HI_W = DATA_SIZE - 8 * (BYTES_PER_SAMPLE - 1);
  localparam logic [ADDR_SIZE:0] FRAME_LEN = {1'b1, {ADDR_SIZE{1'b0}}};

  state_t               state, next_state;
  logic                 full_s, full_d, start_q;
  logic [ADDR_SIZE:0]   cnt;
  logic [DATA_SIZE-1:0] sample_q, hi_src;
  logic                 accept;

  logic       r_en_d, tx_valid_d, busy_d, done_d;
  logic [7:0] tx_data_d;

  sync_2ff u_full_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (fifo_full_i),
    .q   (full_s)
  );

  // Registered rising-edge detect on the synchronised full level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_d  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      full_d  <= full_s;
      start_q <= full_s & ~full_d;
    end
  end

  assign accept = tx_valid_o & tx_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start_q) next_state = ST_HEADER;
      ST_HEADER:  if (accept)  next_state = ST_READ;
      // The empty check is taken on the way into READ so r_en_o can be a
      // registered output; r_en_o high here means a read was issued.
      ST_READ:    next_state = r_en_o ? ST_CAPTURE : ST_DONE;
      ST_CAPTURE: next_state = ST_SEND_HI;
      ST_SEND_HI: if (accept)  next_state = ST_SEND_LO;
      ST_SEND_LO: if (accept)  next_state = (cnt == FRAME_LEN) ? ST_DONE : ST_READ;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on next_state.
  always_comb begin
    r_en_d     = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    // In CAPTURE the sample register is still loading, so the high byte is
    // taken straight from the FIFO bus; afterwards the register holds it.
    hi_src     = (state == ST_CAPTURE) ? fifo_data_i : sample_q;
    case (next_state)
      ST_HEADER: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER;
        busy_d     = 1'b1;
      end
      ST_READ: begin
        r_en_d = ~fifo_empty_i;
        busy_d = 1'b1;
      end
      ST_CAPTURE: busy_d = 1'b1;
      ST_SEND_HI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = 8'(hi_src[DATA_SIZE-1 -: HI_W]);
        busy_d     = 1'b1;
      end
      ST_SEND_LO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_q[7:0];
        busy_d     = 1'b1;
      end
      ST_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en_o       <= 1'b0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      r_en_o       <= r_en_d;
      tx_valid_o   <= tx_valid_d;
      tx_data_o    <= tx_data_d;
      busy_o       <= busy_d;
      frame_done_o <= done_d;
    end
  end

  // Sample register and per-frame sample counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q <= '0;
      cnt      <= '0;
    end else begin
      if (state == ST_IDLE && start_q) cnt <= '0;
      if (state == ST_CAPTURE) begin
        sample_q <= fifo_data_i;
        cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_readout.sv
module tb_sample_readout;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [11:0] fifo_data_i;
  logic        fifo_empty_i;
  logic        fifo_full_i;
  logic        r_en_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;

  sample_readout dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_full_i  (fifo_full_i),
    .r_en_o       (r_en_o),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, empty native to this clock.
  logic [11:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_err = 0;
  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (r_en_o) begin
      if (wr_ptr == rd_ptr) rd_empty_err <= rd_empty_err + 1;
      else begin
        fifo_data_i <= mem[rd_ptr % 1024];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [7:0] rx [0:4095];
  int   rx_n = 0, ren_cnt = 0, done_cnt = 0, stab_err = 0;
  int   cyc = 0, last_acc = 0, done_cyc = 0;
  logic prev_pending = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_valid_o && tx_ready_i) begin
      rx[rx_n % 4096] = tx_data_o;
      rx_n = rx_n + 1;
      last_acc = cyc;
    end
    if (frame_done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (r_en_o) ren_cnt = ren_cnt + 1;
    if (prev_pending && !rst_i && (!tx_valid_o || tx_data_o !== prev_data))
      stab_err = stab_err + 1;
    prev_pending = tx_valid_o && !tx_ready_i && !rst_i;
    prev_data    = tx_data_o;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [11:0] v);
    mem[wr_ptr % 1024] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n = 0;
    while (!frame_done_o && n < limit) begin
      tick(1);
      n++;
    end
    ok = frame_done_o;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tick(2);
    checks++; if (r_en_o !== 1'b0) begin errors++; $display("FAIL reset_r_en got %b want 0", r_en_o); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done_o); end
    rst_i = 1'b0;
    tick(2);
  endtask

  task automatic test_full_frame;
    int b = rx_n, r0 = ren_cnt, d0 = done_cnt, bad = 0;
    bit ok;
    logic [7:0] lo;
    for (int i = 0; i < 256; i++) push(12'(i));
    tx_ready_i  = 1'b1;   // ready already high before valid rises
    fifo_full_i = 1'b1;
    tick(3);
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL start_latency_early got %b want 0", tx_valid_o); end
    tick(1);
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hA5 || busy_o !== 1'b1)
      begin errors++; $display("FAIL start_latency got v=%b d=%h busy=%b want 1 a5 1", tx_valid_o, tx_data_o, busy_o); end
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_frame_timeout got no done want done"); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got %b want 0", busy_o); end
    tick(3);
    fifo_full_i = 1'b0;
    tick(4);
    checks++; if (rx_n - b !== 513) begin errors++; $display("FAIL full_byte_count got %0d want 513", rx_n - b); end
    checks++; if (rx[b % 4096] !== 8'hA5) begin errors++; $display("FAIL full_header got %h want a5", rx[b % 4096]); end
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i);
      if (rx[(b + 1 + 2*i) % 4096] !== 8'h00 || rx[(b + 2 + 2*i) % 4096] !== lo) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_payload got %0d bad samples want 0", bad); end
    checks++; if (ren_cnt - r0 !== 256) begin errors++; $display("FAIL full_r_en_count got %0d want 256", ren_cnt - r0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (done_cyc - last_acc !== 1) begin errors++; $display("FAIL full_done_timing got %0d want 1", done_cyc - last_acc); end
  endtask

  task automatic test_backpressure;
    int b = rx_n, r0 = ren_cnt, s0 = stab_err;
    bit ok;
    int n = 0;
    logic [31:0] pat = 32'b1011_0010_0110_0001_1100_1010_0011_0100;
    push(12'hABC);
    tx_ready_i  = 1'b0;
    fifo_full_i = 1'b1;
    while (!frame_done_o && n < 300) begin
      tx_ready_i = pat[n % 32];
      tick(1);
      n++;
    end
    ok = frame_done_o;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    fifo_full_i = 1'b0;
    tx_ready_i  = 1'b0;
    tick(4);
    checks++; if (rx_n - b !== 3) begin errors++; $display("FAIL bp_byte_count got %0d want 3", rx_n - b); end
    checks++; if (rx[(b+1) % 4096] !== 8'h0A || rx[(b+2) % 4096] !== 8'hBC)
      begin errors++; $display("FAIL bp_bytes got %h %h want 0a bc", rx[(b+1) % 4096], rx[(b+2) % 4096]); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL bp_stability got %0d violations want 0", stab_err - s0); end
    checks++; if (ren_cnt - r0 !== 1) begin errors++; $display("FAIL bp_r_en_count got %0d want 1", ren_cnt - r0); end
  endtask

  task automatic test_early_empty;
    int b = rx_n, r0 = ren_cnt, d0 = done_cnt, e0 = rd_empty_err;
    bit ok;
    logic [7:0] exp [0:6];
    int bad = 0;
    exp[0] = 8'hA5; exp[1] = 8'h01; exp[2] = 8'h23; exp[3] = 8'h04;
    exp[4] = 8'h56; exp[5] = 8'h07; exp[6] = 8'h89;
    push(12'h123); push(12'h456); push(12'h789);
    tx_ready_i  = 1'b1;
    fifo_full_i = 1'b1;
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_timeout got no done want done"); end
    fifo_full_i = 1'b0;
    tick(4);
    checks++; if (rx_n - b !== 7) begin errors++; $display("FAIL early_byte_count got %0d want 7", rx_n - b); end
    for (int i = 0; i < 7; i++) if (rx[(b+i) % 4096] !== exp[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL early_bytes got %0d wrong want 0", bad); end
    checks++; if (ren_cnt - r0 !== 3) begin errors++; $display("FAIL early_r_en_count got %0d want 3", ren_cnt - r0); end
    checks++; if (rd_empty_err - e0 !== 0) begin errors++; $display("FAIL early_read_when_empty got %0d want 0", rd_empty_err - e0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL early_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_no_retrigger;
    int b = rx_n, d0 = done_cnt, busy_seen = 0;
    bit ok;
    push(12'h0FF);
    tx_ready_i  = 1'b1;
    fifo_full_i = 1'b1;
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL noretrig_timeout got no done want done"); end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy_o || tx_valid_o) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL noretrig_idle got %0d busy cycles want 0", busy_seen); end
    checks++; if (rx_n - b !== 3 || done_cnt - d0 !== 1)
      begin errors++; $display("FAIL noretrig_counts got bytes=%0d done=%0d want 3 1", rx_n - b, done_cnt - d0); end
    fifo_full_i = 1'b0;
    tick(4);
    push(12'h9A5);
    fifo_full_i = 1'b1;
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retrig_timeout got no done want done"); end
    fifo_full_i = 1'b0;
    tick(4);
    checks++; if (rx_n - b !== 6 || rx[(b+3) % 4096] !== 8'hA5 || rx[(b+4) % 4096] !== 8'h09 || rx[(b+5) % 4096] !== 8'hA5)
      begin errors++; $display("FAIL retrig_frame got n=%0d %h %h %h want 6 a5 09 a5", rx_n - b,
        rx[(b+3) % 4096], rx[(b+4) % 4096], rx[(b+5) % 4096]); end
  endtask

  task automatic test_reset_mid_frame;
    int b = rx_n, n = 0;
    bit ok;
    push(12'h111); push(12'h222); push(12'h333); push(12'h444);
    tx_ready_i  = 1'b1;
    fifo_full_i = 1'b1;
    while (rx_n - b < 2 && n < 200) begin
      tick(1);
      n++;
    end
    tx_ready_i = 1'b0;
    checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h11)
      begin errors++; $display("FAIL midrst_in_send_lo got v=%b d=%h want 1 11", tx_valid_o, tx_data_o); end
    rst_i       = 1'b1;
    fifo_full_i = 1'b0;
    tick(1);
    checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || r_en_o !== 1'b0 || frame_done_o !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got v=%b busy=%b ren=%b done=%b want 0 0 0 0",
        tx_valid_o, busy_o, r_en_o, frame_done_o); end
    rst_i = 1'b0;
    tick(4);
    b = rx_n;
    tx_ready_i  = 1'b1;
    fifo_full_i = 1'b1;
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_restart_timeout got no done want done"); end
    fifo_full_i = 1'b0;
    tick(4);
    checks++; if (rx_n - b !== 7 || rx[b % 4096] !== 8'hA5 || rx[(b+1) % 4096] !== 8'h02 || rx[(b+2) % 4096] !== 8'h22)
      begin errors++; $display("FAIL midrst_restart_frame got n=%0d %h %h %h want 7 a5 02 22", rx_n - b,
        rx[b % 4096], rx[(b+1) % 4096], rx[(b+2) % 4096]); end
  endtask

  initial begin
    rst_i       = 1'b1;
    fifo_full_i = 1'b0;
    tx_ready_i  = 1'b0;
    fifo_data_i = 12'h000;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_early_empty();
    test_no_retrigger();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
